// File: rtl/cordic_result_collector.sv
// rtl/cordic_result_collector.sv - CORDIC output qualifier and show-ahead result FIFO; optional gain compensation under CORDIC_GAIN_COMP_EN
module cordic_result_collector #(
    parameter int WIDTH        = 16,
    parameter int FRAC_WIDTH   = 8,
    parameter int PIPE_LATENCY = 6,
    parameter int DEPTH        = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [WIDTH-1:0]     y_in,
    input  logic [WIDTH-1:0]     degree_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     x_res,
    output logic [WIDTH-1:0]     y_res,
    output logic [WIDTH-1:0]     degree_res,
    output logic [CNT_WIDTH-1:0] fifo_count,
    output logic                 overflow,
    input  logic                 clear_overflow
);

    localparam int AW = $clog2(DEPTH);

    // Elaboration-time parameter sanity checks
    generate
        if (CNT_WIDTH != $clog2(DEPTH + 1)) begin : g_bad_cnt_width
            $error("CNT_WIDTH must equal clog2(DEPTH+1)");
        end
        if (FRAC_WIDTH >= WIDTH) begin : g_bad_frac_width
            $error("FRAC_WIDTH must be smaller than WIDTH");
        end
    endgenerate

    // Valid delay line mirroring the pipeline depth
    logic [PIPE_LATENCY-1:0] vdly_q, vdly_d;
    logic                    res_valid;

    generate
        if (PIPE_LATENCY == 1) begin : g_dly_one
            assign vdly_d = in_valid;
        end else begin : g_dly_many
            assign vdly_d = {vdly_q[PIPE_LATENCY-2:0], in_valid};
        end
    endgenerate

    assign res_valid = vdly_q[PIPE_LATENCY-1];

    // Write-side view of the qualified result (optionally gain compensated)
    logic             wr_valid;
    logic [WIDTH-1:0] wr_x, wr_y, wr_deg;

`ifdef CORDIC_GAIN_COMP_EN
    // K = 0.607253 in Q1.15; products are signed and truncated after >>15
    localparam logic signed [WIDTH+15:0] GAIN_K = (WIDTH+16)'(19898);

    logic signed [WIDTH+15:0] x_ext, y_ext, x_prod, y_prod;
    logic                     gv_q;
    logic [WIDTH-1:0]         gx_q, gy_q, gdeg_q;

    assign x_ext  = {{16{x_in[WIDTH-1]}}, x_in};
    assign y_ext  = {{16{y_in[WIDTH-1]}}, y_in};
    assign x_prod = x_ext * GAIN_K;
    assign y_prod = y_ext * GAIN_K;

    // Gain stage register: valid and data move together, adding one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gv_q   <= 1'b0;
            gx_q   <= '0;
            gy_q   <= '0;
            gdeg_q <= '0;
        end else begin
            gv_q   <= res_valid;
            gx_q   <= WIDTH'(x_prod >>> 15);
            gy_q   <= WIDTH'(y_prod >>> 15);
            gdeg_q <= degree_in;
        end
    end

    assign wr_valid = gv_q;
    assign wr_x     = gx_q;
    assign wr_y     = gy_q;
    assign wr_deg   = gdeg_q;
`else
    assign wr_valid = res_valid;
    assign wr_x     = x_in;
    assign wr_y     = y_in;
    assign wr_deg   = degree_in;
`endif

    // FIFO state
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [WIDTH-1:0]     x_res_q, x_res_d;
    logic [WIDTH-1:0]     y_res_q, y_res_d;
    logic [WIDTH-1:0]     deg_res_q, deg_res_d;
    logic [WIDTH-1:0]     x_mem   [DEPTH];
    logic [WIDTH-1:0]     y_mem   [DEPTH];
    logic [WIDTH-1:0]     deg_mem [DEPTH];

    logic full, empty, pop, push, drop;

    // Handshake decode: a full FIFO still takes a write when the head leaves this cycle
    always_comb begin
        full  = (count_q == CNT_WIDTH'(DEPTH));
        empty = (count_q == '0);
        pop   = !empty && out_ready;
        push  = wr_valid && (!full || pop);
        drop  = wr_valid && full && !pop;
    end

    // Pointer, occupancy and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Next head value; the slot being written this edge is forwarded from the write data
    always_comb begin
        x_res_d   = x_res_q;
        y_res_d   = y_res_q;
        deg_res_d = deg_res_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                x_res_d   = wr_x;
                y_res_d   = wr_y;
                deg_res_d = wr_deg;
            end else begin
                x_res_d   = x_mem[rd_ptr_d];
                y_res_d   = y_mem[rd_ptr_d];
                deg_res_d = deg_mem[rd_ptr_d];
            end
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            x_mem[wr_ptr_q]   <= wr_x;
            y_mem[wr_ptr_q]   <= wr_y;
            deg_mem[wr_ptr_q] <= wr_deg;
        end
    end

    // Control and head registers; reset also flushes in-flight valids
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vdly_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            x_res_q    <= '0;
            y_res_q    <= '0;
            deg_res_q  <= '0;
        end else begin
            vdly_q     <= vdly_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            x_res_q    <= x_res_d;
            y_res_q    <= y_res_d;
            deg_res_q  <= deg_res_d;
        end
    end

    assign out_valid  = !empty;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign x_res      = x_res_q;
    assign y_res      = y_res_q;
    assign degree_res = deg_res_q;

endmodule

// File: tb/tb_cordic_result_collector.sv
// tb/tb_cordic_result_collector.sv - self-checking bench for cordic_result_collector
`timescale 1ns/1ps
module tb_cordic_result_collector;

    localparam int PL    = 6;
    localparam int DEPTH = 8;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int          LAT  = PL + 1;
    localparam logic [15:0] T2_X = 16'h009B;
    localparam logic [15:0] T2_Y = 16'h004D;
`else
    localparam int          LAT  = PL;
    localparam logic [15:0] T2_X = 16'h0100;
    localparam logic [15:0] T2_Y = 16'h0080;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] x_in, y_in, degree_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x_res, y_res, degree_res;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        clear_overflow;

    cordic_result_collector dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .x_in           (x_in),
        .y_in           (y_in),
        .degree_in      (degree_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .x_res          (x_res),
        .y_res          (y_res),
        .degree_res     (degree_res),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] d;
    } res_t;

    typedef struct {
        bit          iv;
        bit          rdy;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] d;
        logic [15:0] ex;
        logic [15:0] ey;
    } vec_t;

    res_t        sb[$];
    res_t        last_pop;
    logic        exp_ovf;
    int          checks;
    int          failures;
    int          cyc;
    bit          sdv [4096];
    logic [15:0] sx  [4096];
    logic [15:0] sy  [4096];
    logic [15:0] sd  [4096];
    bit          pv  [4096];
    res_t        pe  [4096];
    vec_t        vecs[24];

    function automatic logic [15:0] gain_fn(input logic [15:0] v);
`ifdef CORDIC_GAIN_COMP_EN
        int p;
        p = $signed(v) * 19898;
        return 16'(p >>> 15);
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_state();
        res_t h;
        logic ev;
        ev = (sb.size() != 0);
        h  = ev ? sb[0] : last_pop;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("fifo_count", 32'(fifo_count), 32'(sb.size()));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("x_res", 32'(x_res), 32'(h.x));
        chk("y_res", 32'(y_res), 32'(h.y));
        chk("degree_res", 32'(degree_res), 32'(h.d));
    endtask

    task automatic step(input bit iv, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] d, input logic [15:0] ex, input logic [15:0] ey,
                        input bit rdy, input bit clr);
        bit dropped;
        check_state();
        in_valid = iv;
        if (iv) begin
            sdv[cyc+PL] = 1'b1;
            sx[cyc+PL]  = x;
            sy[cyc+PL]  = y;
            sd[cyc+PL]  = d;
            pv[cyc+LAT] = 1'b1;
            pe[cyc+LAT] = '{x: ex, y: ey, d: d};
        end
        if (sdv[cyc]) begin
            x_in      = sx[cyc];
            y_in      = sy[cyc];
            degree_in = sd[cyc];
        end else begin
            x_in      = 16'($urandom);
            y_in      = 16'($urandom);
            degree_in = 16'($urandom);
        end
        out_ready      = rdy;
        clear_overflow = clr;
        dropped        = 1'b0;
        if (rdy && sb.size() != 0) last_pop = sb.pop_front();
        if (pv[cyc]) begin
            if (sb.size() < DEPTH) sb.push_back(pe[cyc]);
            else dropped = 1'b1;
        end
        if (dropped) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] d,
                        input bit rdy);
        step(1'b1, x, y, d, gain_fn(x), gain_fn(y), rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, '0, '0, '0, '0, '0, rdy, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_x_res"}, 32'(x_res), 32'd0);
        chk({tag, "_y_res"}, 32'(y_res), 32'd0);
        chk({tag, "_deg_res"}, 32'(degree_res), 32'd0);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        cyc++;
        check_zero("rst_next");
        reset = 1'b1;
        for (int i = cyc - 2; i <= cyc + LAT + 2; i++) begin
            sdv[i] = 1'b0;
            pv[i]  = 1'b0;
        end
        sb.delete();
        exp_ovf  = 1'b0;
        last_pop = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lat;
        int seen;
        logic [15:0] cap_x, cap_y;

        checks = 0; failures = 0; cyc = 100;
        exp_ovf = 1'b0; last_pop = '0;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
        x_in = '0; y_in = '0; degree_in = '0;

        for (int i = 0; i < 24; i++) begin
            vecs[i].iv  = (i % 5) != 3;
            vecs[i].rdy = (i % 3) != 0;
            vecs[i].x   = 16'(i * 16'h1357 + 16'h8001);
            vecs[i].y   = 16'(16'h0F00 - i * 16'h0321);
            vecs[i].d   = 16'(16'hA000 + i);
            vecs[i].ex  = gain_fn(vecs[i].x);
            vecs[i].ey  = gain_fn(vecs[i].y);
        end

        repeat (2) @(posedge clk);
        #1;
        check_zero("init");
        reset = 1'b1;

        // Single result latency and value
        t0 = cyc; lat = -1; cap_x = '0; cap_y = '0;
        send(16'h0100, 16'h0080, 16'h0011, 1'b1);
        for (int k = 0; k < LAT + 4; k++) begin
            if (out_valid && lat < 0) begin
                lat = cyc - t0; cap_x = x_res; cap_y = y_res;
            end
            idle(1, 1'b1);
        end
        chk("t2_latency", 32'(lat), 32'(LAT + 1));
        chk("t2_x", 32'(cap_x), 32'(T2_X));
        chk("t2_y", 32'(cap_y), 32'(T2_Y));

        // Overfill then drain in order
        for (int i = 0; i < DEPTH + 2; i++) send(16'(16'h3000 + i), 16'(16'h0300 + i), 16'(i), 1'b0);
        idle(LAT + 1, 1'b0);
        chk("t3_count_full", 32'(fifo_count), 32'd8);
        chk("t3_overflow", 32'(overflow), 32'd1);
        idle(DEPTH + 2, 1'b1);
        chk("t3_drained", 32'(fifo_count), 32'd0);
        step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        chk("t3_clear", 32'(overflow), 32'd0);

        // Full FIFO with pop on every arriving result
        for (int i = 0; i < DEPTH; i++) send(16'(16'h4000 + i), 16'(16'h0400 + i), 16'(i), 1'b0);
        idle(LAT, 1'b0);
        for (int i = 0; i < 3; i++) send(16'(16'h5000 + i), 16'(16'h0500 + i), 16'(i), 1'b0);
        for (int k = 0; k < LAT + 2; k++) step(1'b0, '0, '0, '0, '0, '0, pv[cyc], 1'b0);
        chk("t4_count", 32'(fifo_count), 32'd8);
        chk("t4_overflow", 32'(overflow), 32'd0);

        // Clear collides with a drop: set wins
        send(16'h6000, 16'h0600, 16'h0006, 1'b0);
        for (int k = 0; k < LAT + 1; k++) step(1'b0, '0, '0, '0, '0, '0, 1'b0, pv[cyc]);
        chk("t5_set_wins", 32'(overflow), 32'd1);
        step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        chk("t5_clear_alone", 32'(overflow), 32'd0);
        send(16'h6001, 16'h0601, 16'h0007, 1'b0);
        idle(LAT + 1, 1'b0);
        chk("t5_drop_again", 32'(overflow), 32'd1);

        // Reset mid-run with a full FIFO and overflow set
        do_reset();

        // Reset pulse while a sample is in flight
        send(16'h7777, 16'h0777, 16'h0077, 1'b1);
        idle(1, 1'b1);
        do_reset();
        seen = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            if (out_valid) seen++;
            idle(1, 1'b1);
        end
        chk("t6_no_stale", 32'(seen), 32'd0);

        // Table-driven mixed traffic
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].iv, vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].ex, vecs[i].ey,
                 vecs[i].rdy, 1'b0);
        end
        idle(LAT + DEPTH + 4, 1'b1);
        chk("tbl_drained", 32'(fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
